// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and helpers for the sprite blitter family.
package sprite_pkg;

   localparam int XSCREEN = 160;
   localparam int YSCREEN = 120;
   localparam int SPRITE_W = 30;
   localparam int SPRITE_H = 30;
   localparam int COLOUR_BITS = 3;

   localparam logic [COLOUR_BITS-1:0] TRANSPARENT = 3'd0;
   localparam logic [COLOUR_BITS-1:0] ERASE_COLOUR = 3'd0;
   localparam logic [COLOUR_BITS-1:0] C_BLACK = 3'd0;
   localparam logic [COLOUR_BITS-1:0] C_BLUE = 3'd1;
   localparam logic [COLOUR_BITS-1:0] C_GREEN = 3'd2;
   localparam logic [COLOUR_BITS-1:0] C_RED = 3'd4;
   localparam logic [COLOUR_BITS-1:0] C_WHITE = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_FLUSH,
      S_DONE
   } state_t;

   function automatic int addr_width(input int w, input int h);
      return $clog2(w * h);
   endfunction

   localparam int ADDR_W = addr_width(SPRITE_W, SPRITE_H);

endpackage

// File: rtl/sprite_blitter_if.sv
// Start handshake, sprite ROM port and vga_adapter plot port.
interface sprite_blitter_if;
   import sprite_pkg::*;

   logic start;
   logic [7:0] sprite_x;
   logic [6:0] sprite_y;
   logic erase;
   logic busy;
   logic done;
   logic [ADDR_W-1:0] rom_address;
   logic [COLOUR_BITS-1:0] rom_q;
   logic [7:0] x;
   logic [6:0] y;
   logic [COLOUR_BITS-1:0] colour;
   logic plot;

   modport master (
      output start, sprite_x, sprite_y, erase, rom_q,
      input busy, done, rom_address, x, y, colour, plot
   );

   modport slave (
      input start, sprite_x, sprite_y, erase, rom_q,
      output busy, done, rom_address, x, y, colour, plot
   );

endinterface

// File: rtl/sprite_scan_counter.sv
// Raster col/row counter with clear, enable and last-pixel flag.
module sprite_scan_counter #(
   parameter int W = 30,
   parameter int H = 30,
   parameter int CW = $clog2(W),
   parameter int RW = $clog2(H)
) (
   input logic clk,
   input logic rst,
   input logic clr,
   input logic en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic last
);

   logic col_end;
   logic row_end;

   assign col_end = (col == CW'(W - 1));
   assign row_end = (row == RW'(H - 1));
   assign last = col_end && row_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Walks a sprite ROM and streams clipped pixel writes to the framebuffer.
module sprite_blitter
   import sprite_pkg::*;
(
   input logic CLOCK_50,
   input logic reset,
   sprite_blitter_if.slave bus
);

   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);

   state_t state, state_nx;

   logic [7:0] sx;
   logic [6:0] sy;
   logic er;
   logic flush_cnt;

   logic scan_clr, scan_en, scan_last;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic v0, v1;
   logic [CW-1:0] col0;
   logic [RW-1:0] row0;
   logic [ADDR_W-1:0] addr;
   logic [8:0] px;
   logic [7:0] py;
   logic hit;

   logic busy_r, done_r, plot_r;
   logic [7:0] x_r;
   logic [6:0] y_r;
   logic [COLOUR_BITS-1:0] colour_r;

   sprite_scan_counter #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
      .clk(CLOCK_50),
      .rst(reset),
      .clr(scan_clr),
      .en(scan_en),
      .col(col),
      .row(row),
      .last(scan_last)
   );

   always_comb begin
      state_nx = state;
      scan_clr = 1'b0;
      scan_en = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nx = S_DRAW;
               scan_clr = 1'b1;
            end
         end
         S_DRAW: begin
            scan_en = 1'b1;
            if (scan_last) state_nx = S_FLUSH;
         end
         S_FLUSH: if (flush_cnt) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Clip on the widened coordinates so overflow never wraps on screen.
   assign hit = v1
      && (px < 9'(XSCREEN))
      && (py < 8'(YSCREEN))
      && (er || (bus.rom_q != TRANSPARENT));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         sx <= '0;
         sy <= '0;
         er <= 1'b0;
         flush_cnt <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         v0 <= 1'b0;
         v1 <= 1'b0;
         col0 <= '0;
         row0 <= '0;
         addr <= '0;
         px <= '0;
         py <= '0;
         plot_r <= 1'b0;
         x_r <= '0;
         y_r <= '0;
         colour_r <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && bus.start) begin
            sx <= bus.sprite_x;
            sy <= bus.sprite_y;
            er <= bus.erase;
         end
         flush_cnt <= (state == S_FLUSH) ? ~flush_cnt : 1'b0;
         busy_r <= (state != S_IDLE);
         done_r <= (state == S_DONE);
         v0 <= scan_en;
         if (scan_en) begin
            addr <= ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
            col0 <= col;
            row0 <= row;
         end
         v1 <= v0;
         px <= {1'b0, sx} + 9'(col0);
         py <= {1'b0, sy} + 8'(row0);
         plot_r <= hit;
         if (hit) begin
            x_r <= px[7:0];
            y_r <= py[6:0];
            colour_r <= er ? ERASE_COLOUR : bus.rom_q;
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.rom_address = addr;
   assign bus.x = x_r;
   assign bus.y = y_r;
   assign bus.colour = colour_r;
   assign bus.plot = plot_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed scoreboard bench for sprite_blitter.
module tb_sprite_blitter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [31:0] cyc;
   } pix_t;

   logic clk;
   logic rst;
   int cyc = 0;
   int checks = 0;
   int fails = 0;
   int plot_count = 0;
   logic prev_busy = 1'b0;
   logic [7:0] lx = '0;
   logic [6:0] ly = '0;
   logic [2:0] lc = '0;
   logic [2:0] rom [0:1023];
   pix_t sb [$];

   sprite_blitter_if bus ();

   sprite_blitter dut (
      .CLOCK_50(clk),
      .reset(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) bus.rom_q <= rom[bus.rom_address];

   always @(negedge clk) begin
      pix_t got, exp;
      if (!rst) begin
         if (bus.plot) begin
            plot_count++;
            checks++;
            assert (sb.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_plot got x=%0d y=%0d cyc=%0d want none",
                  bus.x, bus.y, cyc);
            end
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               got.x = bus.x;
               got.y = bus.y;
               got.c = bus.colour;
               got.cyc = cyc;
               assert (got === exp) else begin
                  fails++;
                  $error("FAIL plot got x=%0d y=%0d c=%0d cyc=%0d want x=%0d y=%0d c=%0d cyc=%0d",
                     got.x, got.y, got.c, got.cyc, exp.x, exp.y, exp.c, exp.cyc);
               end
            end
         end else if (bus.busy && prev_busy) begin
            checks++;
            assert ({bus.x, bus.y, bus.colour} === {lx, ly, lc}) else begin
               fails++;
               $error("FAIL hold got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                  bus.x, bus.y, bus.colour, lx, ly, lc);
            end
         end
      end
      lx = bus.x;
      ly = bus.y;
      lc = bus.colour;
      prev_busy = bus.busy;
   end

   task automatic load_rom(input int mode);
      for (int a = 0; a < 1024; a++) begin
         case (mode)
            0: rom[a] = 3'(a % 7 + 1);
            1: rom[a] = (a % 30 == 0) ? 3'd0 : 3'(a % 7 + 1);
            default: rom[a] = 3'd0;
         endcase
      end
   endtask

   task automatic do_start(input logic [7:0] sx, input logic [6:0] sy,
                           input logic e, input logic hold, output int t0);
      @(negedge clk);
      bus.sprite_x = sx;
      bus.sprite_y = sy;
      bus.erase = e;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      if (!hold) bus.start = 1'b0;
      plot_count = 0;
      for (int i = 0; i < 900; i++) begin
         int col, row, px, py;
         pix_t p;
         col = i % 30;
         row = i / 30;
         px = int'(sx) + col;
         py = int'(sy) + row;
         if (px < 160 && py < 120 && (e || rom[i] != 3'd0)) begin
            p.x = 8'(px);
            p.y = 7'(py);
            p.c = e ? 3'd0 : rom[i];
            p.cyc = 32'(t0 + 3 + i);
            sb.push_back(p);
         end
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      assert (bus.busy === 1'b1) else begin
         fails++;
         $error("FAIL busy_rise got=%0b want=1", bus.busy);
      end
   endtask

   task automatic run_to_done(input int t0, input int exp_n, input string tag);
      bit seen;
      int dc;
      seen = 0;
      dc = -1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            dc = cyc - t0;
            bus.start = 1'b0;
            break;
         end
      end
      checks++;
      assert (seen && dc == 903 && bus.busy === 1'b1) else begin
         fails++;
         $error("FAIL %s_done got=%0d busy=%0b want=903 busy=1", tag, dc, bus.busy);
      end
      @(negedge clk);
      checks++;
      assert (bus.busy === 1'b0 && bus.done === 1'b0) else begin
         fails++;
         $error("FAIL %s_idle got busy=%0b done=%0b want 0 0", tag, bus.busy, bus.done);
      end
      checks++;
      assert (plot_count == exp_n) else begin
         fails++;
         $error("FAIL %s_count got=%0d want=%0d", tag, plot_count, exp_n);
      end
      checks++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL %s_left got=%0d want=0", tag, sb.size());
      end
   endtask

   initial begin
      int t0;
      int dones;
      int busys;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.sprite_x = '0;
      bus.sprite_y = '0;
      bus.erase = 1'b0;
      load_rom(0);
      repeat (3) @(negedge clk);
      checks++;
      assert ({bus.busy, bus.done, bus.plot} === 3'b000) else begin
         fails++;
         $error("FAIL reset_ctl got=%b want=000", {bus.busy, bus.done, bus.plot});
      end
      checks++;
      assert ({bus.x, bus.y, bus.colour, bus.rom_address} === 28'd0) else begin
         fails++;
         $error("FAIL reset_data got x=%0d y=%0d c=%0d a=%0d want 0",
            bus.x, bus.y, bus.colour, bus.rom_address);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_start(8'd20, 7'd0, 1'b0, 1'b0, t0);
      run_to_done(t0, 900, "basic");

      load_rom(1);
      do_start(8'd0, 7'd0, 1'b0, 1'b0, t0);
      run_to_done(t0, 870, "transp");

      load_rom(0);
      do_start(8'd150, 7'd100, 1'b0, 1'b0, t0);
      run_to_done(t0, 200, "clip");

      load_rom(2);
      do_start(8'd20, 7'd10, 1'b1, 1'b0, t0);
      run_to_done(t0, 900, "erase");

      load_rom(0);
      do_start(8'd40, 7'd50, 1'b0, 1'b1, t0);
      while (cyc < t0 + 300) @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.start = 1'b1;
      run_to_done(t0, 900, "hold");
      busys = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.busy) busys++;
      end
      checks++;
      assert (busys == 0 && plot_count == 900) else begin
         fails++;
         $error("FAIL hold_repeat got busy=%0d plots=%0d want 0 900", busys, plot_count);
      end

      do_start(8'd10, 7'd5, 1'b0, 1'b0, t0);
      while (cyc < t0 + 400) @(negedge clk);
      checks++;
      assert (bus.plot === 1'b1) else begin
         fails++;
         $error("FAIL pre_reset_plot got=%0b want=1", bus.plot);
      end
      rst = 1'b1;
      #1;
      checks++;
      assert ({bus.plot, bus.busy, bus.done} === 3'b000) else begin
         fails++;
         $error("FAIL midreset got=%b want=000", {bus.plot, bus.busy, bus.done});
      end
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dones = 0;
      busys = 0;
      repeat (920) begin
         @(negedge clk);
         if (bus.done) dones++;
         if (bus.busy) busys++;
      end
      checks++;
      assert (dones == 0 && busys == 0) else begin
         fails++;
         $error("FAIL midreset_quiet got done=%0d busy=%0d want 0 0", dones, busys);
      end
      do_start(8'd60, 7'd30, 1'b0, 1'b0, t0);
      run_to_done(t0, 900, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
